// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: four-digit common-anode seven-segment scan controller.
// Shares one active-low segment bus among four anodes. Each digit is lit for
// DIV clocks, and every digit is followed by BLANK_CYC clocks with all anodes
// off to suppress ghosting. New digit values are staged in a pending register
// and only become visible at a frame boundary, so a single frame never mixes
// old and new values.
// Optional feature: define SEG7_SCAN_LZB_EN to blank leading zeros on digits 3..1.
module seg7_scan_ctrl #(
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_done
);

   // state | meaning
   // BLANK | all anodes off for BLANK_CYC clocks before the next digit
   // SHOW  | anode idx on for DIV clocks, segments decode active digit idx
   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   localparam logic [6:0] SEG_OFF  = 7'b1111111;
   localparam logic [3:0] AN_OFF   = 4'b1111;

   state_t        state;
   logic [1:0]    idx;
   logic [CW-1:0] cnt;
   logic [15:0]   pend_dig;
   logic [3:0]    pend_dp;
   logic [15:0]   act_dig;
   logic [3:0]    act_dp;

   logic [3:0]    cur_digit;
   logic [6:0]    cur_seg;
   logic          cur_blank;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0011000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   // Select the active digit for the current scan position and decide whether it is blanked.
   always_comb begin
      cur_digit = 4'd0;
      cur_blank = 1'b0;
      case (idx)
         2'd0: cur_digit = act_dig[3:0];
         2'd1: cur_digit = act_dig[7:4];
         2'd2: cur_digit = act_dig[11:8];
         default: cur_digit = act_dig[15:12];
      endcase
`ifdef SEG7_SCAN_LZB_EN
      // A digit is a leading zero when it and every digit above it are zero.
      case (idx)
         2'd1: cur_blank = (act_dig[15:4] == 12'd0);
         2'd2: cur_blank = (act_dig[15:8] == 8'd0);
         2'd3: cur_blank = (act_dig[15:12] == 4'd0);
         default: cur_blank = 1'b0;
      endcase
`endif
      cur_seg = cur_blank ? SEG_OFF : decode(cur_digit);
   end

   // Scan FSM: phase timing, digit staging and registered display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= BLANK;
         idx        <= 2'd0;
         cnt        <= '0;
         pend_dig   <= 16'd0;
         pend_dp    <= 4'd0;
         act_dig    <= 16'd0;
         act_dp     <= 4'd0;
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (load) begin
            pend_dig <= digits_in;
            pend_dp  <= dp_in;
         end
         case (state)
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state <= SHOW;
                  cnt   <= '0;
                  an    <= ~(4'b0001 << idx);
                  seg   <= cur_seg;
                  dp    <= ~act_dp[idx];
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               if (cnt == DIV_LAST) begin
                  state <= BLANK;
                  cnt   <= '0;
                  idx   <= idx + 2'd1;
                  an    <= AN_OFF;
                  seg   <= SEG_OFF;
                  dp    <= 1'b1;
                  if (idx == 2'd3) begin
                     // Frame boundary: the old pending value goes live even if
                     // load overwrites pending on this same edge.
                     frame_done <= 1'b1;
                     act_dig    <= pend_dig;
                     act_dp     <= pend_dp;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIV=4, BLANK_CYC=2 (24-clock frame).
// Expected values follow SEG7_SCAN_LZB_EN the same way the design does.
module tb_seg7_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        load;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_done;

   int n_tests;
   int n_fail;

   localparam logic [6:0] S0    = 7'b1000000;
   localparam logic [6:0] S1    = 7'b1111001;
   localparam logic [6:0] S2    = 7'b0100100;
   localparam logic [6:0] S3    = 7'b0110000;
   localparam logic [6:0] S4    = 7'b0011001;
   localparam logic [6:0] S5    = 7'b0010010;
   localparam logic [6:0] S7    = 7'b1111000;
   localparam logic [6:0] SDASH = 7'b0111111;
   localparam logic [6:0] SOFF  = 7'b1111111;

   seg7_scan_ctrl #(.DIV(4), .BLANK_CYC(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .load       (load),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_blank(input string name);
      n_tests++;
      if ({an, seg, dp, frame_done} !== {4'b1111, SOFF, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL %s: an=%b seg=%b dp=%b fd=%b, expected an=1111 seg=1111111 dp=1 fd=0",
                  name, an, seg, dp, frame_done);
      end
   endtask

   task automatic check_digit0(input string name, input logic [6:0] exp_seg);
      n_tests++;
      if ({an, seg, dp, frame_done} !== {4'b1110, exp_seg, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL %s: an=%b seg=%b dp=%b fd=%b, expected an=1110 seg=%b dp=1 fd=0",
                  name, an, seg, dp, frame_done, exp_seg);
      end
   endtask

   // Advance to the sample right after a frame boundary edge.
   task automatic wait_boundary(input string name);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL %s: frame_done never seen within 60 cycles, expected a pulse every 24", name);
      end
   endtask

   // Called at the boundary sample; checks every cycle of the next frame and
   // ends on the following boundary sample. Optionally pulses load before edge ld_k.
   task automatic check_frame(input string name,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dpv,
                              input int ld_k, input logic [15:0] ld_d, input logic [3:0] ld_dp);
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic       e_fd;
      int         j;
      int         slot;
      int         off;
      for (int k = 1; k <= 24; k++) begin
         if (k == ld_k) begin
            digits_in = ld_d;
            dp_in     = ld_dp;
            load      = 1'b1;
         end
         @(negedge clk);
         load = 1'b0;
         j    = k - 1;
         slot = j / 6;
         off  = j % 6;
         e_fd = (k == 24);
         if (off >= 1 && off <= 4) begin
            case (slot)
               0: begin e_an = 4'b1110; e_seg = s0; e_dp = ~dpv[0]; end
               1: begin e_an = 4'b1101; e_seg = s1; e_dp = ~dpv[1]; end
               2: begin e_an = 4'b1011; e_seg = s2; e_dp = ~dpv[2]; end
               default: begin e_an = 4'b0111; e_seg = s3; e_dp = ~dpv[3]; end
            endcase
         end else begin
            e_an  = 4'b1111;
            e_seg = SOFF;
            e_dp  = 1'b1;
         end
         n_tests++;
         if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
            n_fail++;
            $display("FAIL %s k=%0d: an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                     name, k, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
         end
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dpv);
      digits_in = d;
      dp_in     = dpv;
      load      = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      load      = 1'b0;
      digits_in = 16'd0;
      dp_in     = 4'd0;
      repeat (3) @(negedge clk);
      check_blank("reset_hold");
      rst = 1'b0;
      @(negedge clk);
      check_blank("reset_release_blank");
      @(negedge clk);
      check_digit0("reset_first_digit", S0);
   endtask

   task automatic test_1234;
      do_load(16'h1234, 4'b0000);
      wait_boundary("1234_sync");
      check_frame("1234_f1", S4, S3, S2, S1, 4'b0000, 0, 16'h0, 4'h0);
      check_frame("1234_f2", S4, S3, S2, S1, 4'b0000, 0, 16'h0, 4'h0);
   endtask

   task automatic test_hex_dp;
      do_load(16'h00AF, 4'b0010);
      wait_boundary("hex_sync");
`ifdef SEG7_SCAN_LZB_EN
      check_frame("hex_dp", SDASH, SDASH, SOFF, SOFF, 4'b0010, 0, 16'h0, 4'h0);
`else
      check_frame("hex_dp", SDASH, SDASH, S0, S0, 4'b0010, 0, 16'h0, 4'h0);
`endif
   endtask

   task automatic test_lzb;
      do_load(16'h0007, 4'b0000);
      wait_boundary("lzb_0007_sync");
`ifdef SEG7_SCAN_LZB_EN
      check_frame("lzb_0007", S7, SOFF, SOFF, SOFF, 4'b0000, 0, 16'h0, 4'h0);
`else
      check_frame("lzb_0007", S7, S0, S0, S0, 4'b0000, 0, 16'h0, 4'h0);
`endif
      do_load(16'h0407, 4'b0000);
      wait_boundary("lzb_0407_sync");
`ifdef SEG7_SCAN_LZB_EN
      check_frame("lzb_0407", S7, S0, S4, SOFF, 4'b0000, 0, 16'h0, 4'h0);
`else
      check_frame("lzb_0407", S7, S0, S4, S0, 4'b0000, 0, 16'h0, 4'h0);
`endif
   endtask

   task automatic test_back_to_back;
      do_load(16'h1234, 4'b0000);
      wait_boundary("b2b_sync");
      // load while digit 1 is lit: current frame must stay 1234
      check_frame("b2b_midload", S4, S3, S2, S1, 4'b0000, 9, 16'h5555, 4'b0000);
      // load on the boundary edge itself: 1234 only appears one frame later
      check_frame("b2b_5555_a", S5, S5, S5, S5, 4'b0000, 24, 16'h1234, 4'b0000);
      check_frame("b2b_5555_b", S5, S5, S5, S5, 4'b0000, 0, 16'h0, 4'h0);
      check_frame("b2b_1234", S4, S3, S2, S1, 4'b0000, 0, 16'h0, 4'h0);
   endtask

   task automatic test_reset_mid;
      repeat (9) @(negedge clk);
      n_tests++;
      if (an !== 4'b1101) begin
         n_fail++;
         $display("FAIL rmid_pre: an=%b, expected an=1101", an);
      end
      #2 rst = 1'b1;
      #1 check_blank("rmid_immediate");
      @(negedge clk);
      check_blank("rmid_held");
      rst = 1'b0;
      @(negedge clk);
      check_blank("rmid_release_blank");
      @(negedge clk);
      check_digit0("rmid_first_digit", S0);
      wait_boundary("rmid_sync");
`ifdef SEG7_SCAN_LZB_EN
      check_frame("rmid_cleared", S0, SOFF, SOFF, SOFF, 4'b0000, 0, 16'h0, 4'h0);
`else
      check_frame("rmid_cleared", S0, S0, S0, S0, 4'b0000, 0, 16'h0, 4'h0);
`endif
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_1234();
      test_hex_dp();
      test_lzb();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing scan controller for a four-digit common-anode seven-segment display. It shares one segment bus among four digit positions. It latches four BCD digits from the counter datapath and cycles the anode enables with a programmable on-time and an inter-digit blanking gap to suppress ghosting. Digit updates are deferred to frame boundaries so a frame never shows a mix of old and new values.

## Interface
- `DIV`, 50000: clocks each digit is lit (SHOW phase); must be ≥1.
- `BLANK_CYC`, 1000: clocks all anodes are off between digits (BLANK phase); must be ≥1.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `digits_in` in 16: four BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
- `dp_in` in 4: decimal-point request per digit, active-high.
- `load` in 1: single-cycle strobe that captures `digits_in`/`dp_in` into the pending register.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 4: anode enables, active-low; bit i selects digit i.
- `frame_done` out 1: one-cycle pulse at the end of each frame.

## Operation
- Registers:
  - pending (16+4 bits): loaded on any edge with `load`=1.
  - active (16+4 bits): copied from pending at each frame boundary.
  - idx (2 bits).
  - phase counter.
  - state ∈ {BLANK, SHOW}.
- FSM:
  - BLANK lasts exactly BLANK_CYC cycles; `an`=1111, `seg`=1111111, `dp`=1; then go to SHOW.
  - SHOW lasts exactly DIV cycles; `an` has only bit idx low; `seg`/`dp` decode active digit idx; then go to BLANK with idx←idx+1 mod 4.
- Frame boundary: the edge leaving SHOW with idx=3.
  - `frame_done`=1 for the following cycle.
  - active←pending on that edge.
  - If `load` is asserted on that same edge, pending takes the new value, and active takes the old pending value; the new value appears in the next frame.
- Decode (active-low gfedcba):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001
  - 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0011000
  - 10–15→0111111 (dash)
- `dp` = ~active_dp[idx] during SHOW; 1 otherwise.
- All outputs are registered. Output changes coincide with the state-change edge, with no extra cycle of lag.
- Reset (asynchronous, immediate), including mid-operation:
  - `an`=1111, `seg`=1111111, `dp`=1, `frame_done`=0.
  - state=BLANK, idx=0, counter=0.
  - pending and active = 0.

## Timing
- Frame period: 4×(BLANK_CYC+DIV) cycles.
- After reset release, the first BLANK_CYC cycles are blank, then digit 0 is lit for DIV cycles.
- `load` to display latency: from the next frame boundary up to one full frame plus one edge; never mid-frame.
- Exactly one `an` bit is low at any time, or none; two bits are never low simultaneously.
- Counter width is sized to max(DIV, BLANK_CYC) and wraps only via the FSM.

## Configuration
- `SEG7_SCAN_LZB_EN` defined (leading-zero blanking):
  - During SHOW, digit i∈{3,2,1} drives `seg`=1111111 when active digit i and all higher digits are 0.
  - `dp` is still driven from `dp_in`.
  - Digit 0 is never blanked.
- `SEG7_SCAN_LZB_EN` undefined: all digits are always decoded.

## Test plan
- Reset with DIV=4, BLANK_CYC=2 → `an`=1111, `seg`=1111111, `dp`=1, `frame_done`=0; no `an` activity for 2 cycles after release.
- `load` 16'h1234, `dp_in`=0000 → next frame, 4 cycles each with 2-cycle blank gaps:
  - `an`=1110 with `seg`=0011001
  - `an`=1101 with `seg`=0110000
  - `an`=1011 with `seg`=0100100
  - `an`=0111 with `seg`=1111001
  - `frame_done` pulses every 24 cycles.
- `load` 16'h00AF, `dp_in`=0010 → digits 0 and 1 show 0111111; `dp`=0 only while `an`=1101.
- Macro defined, `load` 16'h0007 → digits 3..1 show 1111111, digit 0 shows 1111000. 16'h0407 → digit 1 shows 1000000, digit 3 shows 1111111. Macro undefined, 16'h0007 → digits 3..1 show 1000000.
- Active 16'h1234; `load` 16'h5555 while `an`=1101 → rest of the frame shows 3,2,1; next frame all digits show 0010010. `load` on the boundary edge itself → appears one frame later.
- `rst` pulsed mid-SHOW → outputs blank immediately; after release, 2 blank cycles, then digit 0 shows 1000000 (value 0).
